// File: rtl/router_pkt_ctrl_pkg.sv
// Shared definitions for the 1x3 router packet controller: FSM state
// encodings, the reserved header address and the output port count.
package router_pkg;

   localparam int         NUM_PORTS    = 3;
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_e;

endpackage

// File: rtl/router_pkt_ctrl_if.sv
// Control bundle between the router input pins, the synchroniser/register
// blocks and the packet controller. The master modport is the controller.
interface router_pkt_ctrl_if #(
   parameter int ADDR_W = 2
);
   logic              pkt_valid;
   logic [ADDR_W-1:0] data_in;
   logic              fifo_full;
   logic              fifo_empty_0;
   logic              fifo_empty_1;
   logic              fifo_empty_2;
   logic              soft_reset_0;
   logic              soft_reset_1;
   logic              soft_reset_2;
   logic              parity_done;
   logic              low_pkt_valid;

   logic              detect_add;
   logic              lfd_state;
   logic              ld_state;
   logic              laf_state;
   logic              full_state;
   logic              write_enb_reg;
   logic              rst_int_reg;
   logic              busy;
   logic              timeout_drop;

   modport master (
      input  pkt_valid, data_in, fifo_full,
             fifo_empty_0, fifo_empty_1, fifo_empty_2,
             soft_reset_0, soft_reset_1, soft_reset_2,
             parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, busy, timeout_drop
   );

   modport slave (
      output pkt_valid, data_in, fifo_full,
             fifo_empty_0, fifo_empty_1, fifo_empty_2,
             soft_reset_0, soft_reset_1, soft_reset_2,
             parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, busy, timeout_drop
   );

endinterface

// File: rtl/router_pkt_ctrl.sv
// Packet-level controller FSM for the 1x3 router. Sequences header decode,
// first-data load, payload load, full stall, parity load and parity check.
// Outputs are Moore, decoded from the state register.
// Optional feature: define ROUTER_WAIT_TIMEOUT_EN to drop a packet whose
// target FIFO stays non-empty for WAIT_MAX cycles (pulses timeout_drop).
module router_pkt_ctrl
   import router_pkg::*;
#(
   parameter int ADDR_W   = 2,
   parameter int WAIT_MAX = 255
) (
   input  logic              clock,
   input  logic              reset,
   router_pkt_ctrl_if.master bus
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [NUM_PORTS-1:0] empty_vec, soft_vec;
   logic                hdr_ok, empty_hdr, empty_sel, soft_sel;
   logic                wait_expired;

   // Pick the per-port flag addressed by a; addresses beyond the port count read 0.
   function automatic logic port_bit(input logic [NUM_PORTS-1:0] v,
                                     input logic [ADDR_W-1:0]    a);
      port_bit = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (a == ADDR_W'(i)) port_bit = v[i];
   endfunction

   assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
   assign soft_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
   assign hdr_ok    = bus.pkt_valid && (bus.data_in != ADDR_W'(ADDR_INVALID));
   assign empty_hdr = port_bit(empty_vec, bus.data_in);
   assign empty_sel = port_bit(empty_vec, addr_q);
   assign soft_sel  = port_bit(soft_vec, addr_q);

   // State register and latched destination address.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE_ADDRESS && hdr_ok)
            addr_q <= bus.data_in;
      end
   end

`ifdef ROUTER_WAIT_TIMEOUT_EN
   localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);
   logic [7:0] wait_cnt;

   // Dwell counter: zero outside WAIT_TILL_EMPTY, counts up and holds at the limit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         wait_cnt <= '0;
      else if (state_q != WAIT_TILL_EMPTY)
         wait_cnt <= '0;
      else if (wait_cnt != WAIT_LIMIT)
         wait_cnt <= wait_cnt + 8'd1;
   end

   assign wait_expired     = (state_q == WAIT_TILL_EMPTY) && (wait_cnt == WAIT_LIMIT);
   assign bus.timeout_drop = wait_expired && !empty_sel;
`else
   assign wait_expired     = 1'b0;
   assign bus.timeout_drop = 1'b0;
`endif

   // Next-state logic; soft reset of the active port overrides every transition.
   // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DECODE_ADDRESS:
            if (hdr_ok) state_d = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         LOAD_FIRST_DATA:
            state_d = LOAD_DATA;
         LOAD_DATA:
            if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
            else if (!bus.pkt_valid) state_d = LOAD_PARITY;
         FIFO_FULL_STATE:
            if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
         LOAD_AFTER_FULL:
            if (bus.parity_done)        state_d = DECODE_ADDRESS;
            else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
            else                        state_d = LOAD_DATA;
         LOAD_PARITY:
            state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         WAIT_TILL_EMPTY:
            if (empty_sel)         state_d = LOAD_FIRST_DATA;
            else if (wait_expired) state_d = DECODE_ADDRESS;
         default:
            state_d = DECODE_ADDRESS;
      endcase
      if (state_q != DECODE_ADDRESS && soft_sel)
         state_d = DECODE_ADDRESS;
   end

   // Moore output decode from the registered state.
   always_comb begin
      bus.detect_add    = 1'b0;
      bus.lfd_state     = 1'b0;
      bus.ld_state      = 1'b0;
      bus.laf_state     = 1'b0;
      bus.full_state    = 1'b0;
      bus.write_enb_reg = 1'b0;
      bus.rst_int_reg   = 1'b0;
      bus.busy          = 1'b0;
      unique case (state_q)
         DECODE_ADDRESS:     bus.detect_add = 1'b1;
         LOAD_FIRST_DATA:    begin bus.lfd_state  = 1'b1; bus.busy = 1'b1; end
         LOAD_DATA:          begin bus.ld_state   = 1'b1; bus.write_enb_reg = 1'b1; end
         FIFO_FULL_STATE:    begin bus.full_state = 1'b1; bus.busy = 1'b1; end
         LOAD_AFTER_FULL:    begin bus.laf_state  = 1'b1; bus.busy = 1'b1; bus.write_enb_reg = 1'b1; end
         LOAD_PARITY:        begin bus.busy = 1'b1; bus.write_enb_reg = 1'b1; end
         CHECK_PARITY_ERROR: begin bus.rst_int_reg = 1'b1; bus.busy = 1'b1; end
         WAIT_TILL_EMPTY:    bus.busy = 1'b1;
         default:            bus.detect_add = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Scoreboard bench for router_pkt_ctrl. Stimulus pushes the expected output
// vector for the state reached after each clock edge; a monitor pops and
// compares on every falling edge. Output vector bit order:
// {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy, timeout_drop}
module tb_router_pkt_ctrl;

   localparam logic [8:0] O_DA   = 9'b1_0000_0000;
   localparam logic [8:0] O_LFD  = 9'b0_1000_0010;
   localparam logic [8:0] O_LD   = 9'b0_0100_1000;
   localparam logic [8:0] O_LAF  = 9'b0_0010_1010;
   localparam logic [8:0] O_FFS  = 9'b0_0001_0010;
   localparam logic [8:0] O_LP   = 9'b0_0000_1010;
   localparam logic [8:0] O_CPE  = 9'b0_0000_0110;
   localparam logic [8:0] O_WTE  = 9'b0_0000_0010;
   localparam logic [8:0] O_DROP = 9'b0_0000_0011;

   typedef struct {
      logic [8:0] exp;
      string      name;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [8:0] dut_out;
   exp_t       sb[$];
   int         tests_run    = 0;
   int         tests_failed = 0;

   always #5 clock = ~clock;

   router_pkt_ctrl_if #(.ADDR_W(2)) bus ();

   router_pkt_ctrl #(.ADDR_W(2), .WAIT_MAX(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   assign dut_out = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                     bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy,
                     bus.timeout_drop};

   task automatic expect_out(input logic [8:0] e, input string n);
      sb.push_back('{exp: e, name: n});
   endtask

   // One clock edge, then queue the outputs expected for the new state.
   task automatic cyc(input logic [8:0] e, input string n);
      @(posedge clock);
      #1;
      expect_out(e, n);
   endtask

   // Monitor: compare the DUT outputs against the oldest pending expectation.
   initial begin
      forever begin
         exp_t t;
         @(negedge clock);
         if (sb.size() > 0) begin
            t = sb.pop_front();
            tests_run++;
            if (dut_out !== t.exp) begin
               tests_failed++;
               $display("FAIL %s: got %b expected %b", t.name, dut_out, t.exp);
            end
         end
      end
   end

   initial begin
      reset             = 1'b0;
      bus.pkt_valid     = 1'b0;
      bus.data_in       = 2'b00;
      bus.fifo_full     = 1'b0;
      bus.fifo_empty_0  = 1'b1;
      bus.fifo_empty_1  = 1'b1;
      bus.fifo_empty_2  = 1'b1;
      bus.soft_reset_0  = 1'b0;
      bus.soft_reset_1  = 1'b0;
      bus.soft_reset_2  = 1'b0;
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;
      #3;
      expect_out(O_DA, "reset_state");
      @(negedge clock);
      #2;
      reset = 1'b1;

      // Header to port 1 with empty FIFO, payload, then parity.
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b01;
      cyc(O_LFD, "t1_lfd");
      cyc(O_LD,  "t1_ld");
      cyc(O_LD,  "t1_ld_hold");
      bus.pkt_valid = 1'b0;
      cyc(O_LP,  "t1_lp");
      cyc(O_CPE, "t1_cpe");
      cyc(O_DA,  "t1_da");

      // Header to port 2 with non-empty FIFO: wait, then release.
      bus.pkt_valid    = 1'b1;
      bus.data_in      = 2'b10;
      bus.fifo_empty_2 = 1'b0;
      for (int i = 0; i < 5; i++) cyc(O_WTE, "t2_wait");
      bus.fifo_empty_2 = 1'b1;
      cyc(O_LFD, "t2_lfd");

      // Full stall, resume, low_pkt_valid path, CPE->FFS, parity_done priority.
      cyc(O_LD, "t3_ld");
      bus.pkt_valid = 1'b0;
      bus.fifo_full = 1'b1;
      cyc(O_FFS, "t3_full_prio");
      cyc(O_FFS, "t3_ffs_hold");
      bus.fifo_full     = 1'b0;
      bus.low_pkt_valid = 1'b1;
      cyc(O_LAF, "t3_laf");
      cyc(O_LP,  "t3_laf_low");
      bus.low_pkt_valid = 1'b0;
      bus.fifo_full     = 1'b1;
      cyc(O_CPE, "t3_cpe");
      cyc(O_FFS, "t3_cpe_full");
      bus.fifo_full     = 1'b0;
      bus.parity_done   = 1'b1;
      bus.low_pkt_valid = 1'b1;
      cyc(O_LAF, "t3_laf2");
      cyc(O_DA,  "t3_parity_done");
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;

      // Soft reset: only the active port's flag acts, and never in DA.
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b01;
      cyc(O_LFD, "t4_lfd");
      cyc(O_LD,  "t4_ld");
      bus.soft_reset_0 = 1'b1;
      cyc(O_LD,  "t4_soft0_no_effect");
      bus.soft_reset_0 = 1'b0;
      bus.soft_reset_1 = 1'b1;
      cyc(O_DA,  "t4_soft1_to_da");
      cyc(O_LFD, "t4_soft_ignored_in_da");
      cyc(O_DA,  "t4_soft_from_lfd");
      bus.soft_reset_1 = 1'b0;
      bus.pkt_valid    = 1'b0;
      cyc(O_DA,  "t4_idle");

      // Reserved address ignored; async reset mid-payload.
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b11;
      cyc(O_DA, "t5_addr11_stay");
      cyc(O_DA, "t5_addr11_stay2");
      bus.data_in = 2'b00;
      cyc(O_LFD, "t5_lfd");
      cyc(O_LD,  "t5_ld");
      @(posedge clock);
      #2;
      reset = 1'b0;
      expect_out(O_DA, "t5_async_reset");
      @(negedge clock);
      #2;
      reset         = 1'b1;
      bus.pkt_valid = 1'b0;
      cyc(O_DA, "t5_resume_da");

      // Port 0 never drains.
      bus.pkt_valid    = 1'b1;
      bus.data_in      = 2'b00;
      bus.fifo_empty_0 = 1'b0;
      cyc(O_WTE, "t6_wte");
      bus.pkt_valid = 1'b0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
      for (int i = 0; i < 3; i++) cyc(O_WTE, "t6_wte_count");
      cyc(O_DROP, "t6_timeout_drop");
      cyc(O_DA,   "t6_back_da");
      cyc(O_DA,   "t6_no_repeat");
`else
      for (int i = 0; i < 8; i++) cyc(O_WTE, "t6_wait_forever");
      bus.soft_reset_0 = 1'b1;
      cyc(O_DA, "t6_soft_exit");
      bus.soft_reset_0 = 1'b0;
`endif

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
      #1;
      if (sb.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
